// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator request panel: floor count, floor
// index names and the door sequencing states.
package elevator_pkg;

    localparam int NUM_FLOORS = 6;

    localparam logic [2:0] FLOOR_1  = 3'd0;
    localparam logic [2:0] FLOOR_2  = 3'd1;
    localparam logic [2:0] FLOOR_2M = 3'd2;
    localparam logic [2:0] FLOOR_3  = 3'd3;
    localparam logic [2:0] FLOOR_3M = 3'd4;
    localparam logic [2:0] FLOOR_4  = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        CLOSE = 2'd2
    } door_state_e;

endpackage

// File: rtl/button_sync_edge.sv
// Brings raw call buttons into the clk domain through two flops and emits a
// one-cycle pulse on each synchronized rising edge.
module button_sync_edge #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] pulse
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] prev;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source; with blocking '=' the three
    // stages would collapse into one. Every stage is reset, so a button that
    // was mid-flight when reset hit cannot emit a stale edge after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            sync <= '0;
            prev <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            prev <= sync;
        end
    end

    assign pulse = sync & ~prev;

endmodule

// File: rtl/elevator_request_panel.sv
// Latches hall-call requests per floor and runs the door dwell sequence when
// the car stops at a requested floor, clearing that request as the door closes.
module elevator_request_panel #(
    parameter int DWELL_CYCLES = 8,
    parameter int NUM_FLOORS   = elevator_pkg::NUM_FLOORS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] buttons,
    input  logic                  cancel,
    input  logic [2:0]            floor_idx,
    input  logic                  arrived,
    output logic [NUM_FLOORS-1:0] destination,
    output logic                  door_open,
    output logic [2:0]            pending_count
);

    import elevator_pkg::*;

    localparam logic [7:0] DWELL_LAST  = 8'(DWELL_CYCLES - 1);
    localparam logic [3:0] FLOOR_LIMIT = 4'(NUM_FLOORS);

    door_state_e           state, state_next;
    logic [7:0]            dwell_cnt, dwell_cnt_next;
    logic [2:0]            served_idx, served_idx_next;
    logic [NUM_FLOORS-1:0] btn_pulse;
    logic [NUM_FLOORS-1:0] clear_mask;
    logic [NUM_FLOORS-1:0] dest_next;
    logic [2:0]            count_next;
    logic                  floor_hit;

    button_sync_edge #(
        .WIDTH (NUM_FLOORS)
    ) u_button_sync_edge (
        .clk   (clk),
        .reset (reset),
        .raw   (buttons),
        .pulse (btn_pulse)
    );

    // Out-of-range positions never match, so they can neither open nor clear.
    assign floor_hit = ({1'b0, floor_idx} < FLOOR_LIMIT) && destination[floor_idx];

    // NOTE: every signal written here gets a default before the case, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next      = state;
        dwell_cnt_next  = dwell_cnt;
        served_idx_next = served_idx;
        clear_mask      = '0;

        unique case (state)
            IDLE: begin
                if (arrived && floor_hit) begin
                    state_next      = OPEN;
                    served_idx_next = floor_idx;
                    dwell_cnt_next  = '0;
                end
            end
            OPEN: begin
                if (!arrived) begin
                    state_next = IDLE;
                end else if (btn_pulse[served_idx]) begin
                    dwell_cnt_next = '0;
                end else if (dwell_cnt == DWELL_LAST) begin
                    state_next             = CLOSE;
                    clear_mask[served_idx] = 1'b1;
                end else begin
                    dwell_cnt_next = dwell_cnt + 8'd1;
                end
            end
            CLOSE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (cancel) begin
            state_next     = IDLE;
            dwell_cnt_next = '0;
        end
    end

    // A fresh press on the same edge as the close-out keeps its bit set.
    always_comb begin
        dest_next  = cancel ? '0 : ((destination & ~clear_mask) | btn_pulse);
        count_next = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            count_next = count_next + 3'(dest_next[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            dwell_cnt  <= '0;
            served_idx <= '0;
            door_open  <= 1'b0;
        end else begin
            state      <= state_next;
            dwell_cnt  <= dwell_cnt_next;
            served_idx <= served_idx_next;
            door_open  <= (state_next == OPEN);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            destination   <= '0;
            pending_count <= '0;
        end else begin
            destination   <= dest_next;
            pending_count <= count_next;
        end
    end

endmodule

// File: tb/tb_elevator_request_panel.sv
// Directed scoreboard bench: stimulus queues hand-computed outputs per cycle,
// a negedge monitor pops and compares them against the panel outputs.
module tb_elevator_request_panel;

    import elevator_pkg::*;

    typedef struct {
        string      name;
        logic [5:0] dest;
        logic       door;
        logic [2:0] count;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] buttons;
    logic       cancel;
    logic [2:0] floor_idx;
    logic       arrived;
    logic [5:0] destination;
    logic       door_open;
    logic [2:0] pending_count;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    elevator_request_panel #(
        .DWELL_CYCLES (8),
        .NUM_FLOORS   (6)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .buttons       (buttons),
        .cancel        (cancel),
        .floor_idx     (floor_idx),
        .arrived       (arrived),
        .destination   (destination),
        .door_open     (door_open),
        .pending_count (pending_count)
    );

    always #5 clk = ~clk;

    task automatic check(input exp_t e);
        vectors++;
        if (destination !== e.dest || door_open !== e.door || pending_count !== e.count) begin
            miscompares++;
            $display("FAIL %s: got dest=%b door=%b count=%0d, expected dest=%b door=%b count=%0d",
                     e.name, destination, door_open, pending_count, e.dest, e.door, e.count);
        end
    endtask

    // Queue the outputs expected right now, checked at the coming negedge.
    task automatic expect_now(input string name, input logic [5:0] d,
                              input logic door, input logic [2:0] cnt);
        exp_t e;
        e.name  = name;
        e.dest  = d;
        e.door  = door;
        e.count = cnt;
        sbq.push_back(e);
    endtask

    // Advance one clock edge; optionally queue the outputs expected after it.
    task automatic tick(input string name, input logic [5:0] d, input logic door,
                        input logic [2:0] cnt, input bit chk);
        @(posedge clk);
        #1;
        if (chk) expect_now(name, d, door, cnt);
    endtask

    task automatic skip(input int n);
        for (int i = 0; i < n; i++) tick("", '0, 1'b0, '0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check(e);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset     = 1'b0;
        buttons   = '0;
        cancel    = 1'b0;
        floor_idx = FLOOR_1;
        arrived   = 1'b0;

        skip(2);
        tick("reset_state", 6'b000000, 1'b0, 3'd0, 1'b1);
        reset = 1'b1;
        skip(1);

        // Single press held for five cycles; the set lands on the 3rd edge.
        buttons = 6'b001000;
        tick("press3_edge1", 6'b000000, 1'b0, 3'd0, 1'b1);
        tick("press3_edge2", 6'b000000, 1'b0, 3'd0, 1'b1);
        tick("press3_edge3", 6'b001000, 1'b0, 3'd1, 1'b1);
        tick("press3_hold4", 6'b001000, 1'b0, 3'd1, 1'b1);
        tick("press3_hold5", 6'b001000, 1'b0, 3'd1, 1'b1);
        buttons = '0;
        skip(3);
        buttons = 6'b001000;
        for (int i = 0; i < 4; i++) tick("repress3", 6'b001000, 1'b0, 3'd1, 1'b1);
        buttons = '0;
        skip(3);

        // Plain dwell at floor 3: eight open cycles, one close, then idle.
        floor_idx = FLOOR_3;
        arrived   = 1'b1;
        for (int i = 0; i < 8; i++) tick("dwell3_open", 6'b001000, 1'b1, 3'd1, 1'b1);
        tick("dwell3_close", 6'b000000, 1'b0, 3'd0, 1'b1);
        tick("dwell3_idle", 6'b000000, 1'b0, 3'd0, 1'b1);
        arrived = 1'b0;

        // Dwell extension: re-press after open cycle 5 restarts the count.
        buttons = 6'b001000;
        tick("ext_press1", 6'b000000, 1'b0, 3'd0, 1'b1);
        tick("ext_press2", 6'b000000, 1'b0, 3'd0, 1'b1);
        tick("ext_press3", 6'b001000, 1'b0, 3'd1, 1'b1);
        buttons = '0;
        skip(3);
        arrived = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick("ext_open", 6'b001000, 1'b1, 3'd1, 1'b1);
            if (i == 4) buttons = 6'b001000;
        end
        tick("ext_close", 6'b000000, 1'b0, 3'd0, 1'b1);
        tick("ext_idle", 6'b000000, 1'b0, 3'd0, 1'b1);
        buttons = '0;
        arrived = 1'b0;
        skip(3);

        // Other floors latch during the dwell at floor 2M.
        buttons = 6'b000100;
        tick("press2m_1", 6'b000000, 1'b0, 3'd0, 1'b1);
        tick("press2m_2", 6'b000000, 1'b0, 3'd0, 1'b1);
        tick("press2m_3", 6'b000100, 1'b0, 3'd1, 1'b1);
        buttons = '0;
        skip(3);
        floor_idx = FLOOR_2M;
        arrived   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) tick("dwell2m_open", 6'b000100, 1'b1, 3'd1, 1'b1);
            else       tick("dwell2m_open_more", 6'b100101, 1'b1, 3'd3, 1'b1);
            if (i == 1) buttons = 6'b100001;
            if (i == 5) buttons = '0;
        end
        tick("dwell2m_close", 6'b100001, 1'b0, 3'd2, 1'b1);
        tick("dwell2m_idle", 6'b100001, 1'b0, 3'd2, 1'b1);
        arrived = 1'b0;
        skip(3);

        // Cancel from mid-dwell with destination 100101.
        buttons = 6'b000100;
        tick("refill_1", 6'b100001, 1'b0, 3'd2, 1'b1);
        tick("refill_2", 6'b100001, 1'b0, 3'd2, 1'b1);
        tick("refill_3", 6'b100101, 1'b0, 3'd3, 1'b1);
        buttons = '0;
        skip(3);
        floor_idx = FLOOR_1;
        arrived   = 1'b1;
        tick("cancel_open0", 6'b100101, 1'b1, 3'd3, 1'b1);
        tick("cancel_open1", 6'b100101, 1'b1, 3'd3, 1'b1);
        cancel = 1'b1;
        tick("cancel_edge", 6'b000000, 1'b0, 3'd0, 1'b1);
        cancel = 1'b0;
        tick("cancel_idle", 6'b000000, 1'b0, 3'd0, 1'b1);
        arrived = 1'b0;
        skip(2);

        // Out-of-range floor index is ignored; arrived drop aborts a dwell.
        buttons = 6'b100000;
        skip(2);
        tick("press4_3", 6'b100000, 1'b0, 3'd1, 1'b1);
        buttons = '0;
        skip(3);
        floor_idx = 3'd6;
        arrived   = 1'b1;
        for (int i = 0; i < 3; i++) tick("bad_floor", 6'b100000, 1'b0, 3'd1, 1'b1);
        floor_idx = FLOOR_4;
        tick("abort_open0", 6'b100000, 1'b1, 3'd1, 1'b1);
        tick("abort_open1", 6'b100000, 1'b1, 3'd1, 1'b1);
        arrived = 1'b0;
        tick("abort_idle", 6'b100000, 1'b0, 3'd1, 1'b1);
        tick("abort_hold", 6'b100000, 1'b0, 3'd1, 1'b1);

        // Asynchronous reset mid-dwell discards the served request.
        arrived = 1'b1;
        tick("rst_open0", 6'b100000, 1'b1, 3'd1, 1'b1);
        tick("rst_open1", 6'b100000, 1'b1, 3'd1, 1'b1);
        skip(1);
        reset = 1'b0;
        #1;
        expect_now("async_reset", 6'b000000, 1'b0, 3'd0);
        tick("reset_hold", 6'b000000, 1'b0, 3'd0, 1'b1);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick("no_reopen", 6'b000000, 1'b0, 3'd0, 1'b1);
        arrived = 1'b0;

        // A fresh press after reset release sets its bit normally.
        buttons = 6'b000010;
        tick("post_rst_1", 6'b000000, 1'b0, 3'd0, 1'b1);
        tick("post_rst_2", 6'b000000, 1'b0, 3'd0, 1'b1);
        tick("post_rst_3", 6'b000010, 1'b0, 3'd1, 1'b1);
        buttons = '0;

        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
